// File: rtl/regbank8x64.sv
// regbank8x64: eight-entry register bank fed by a one-hot write select.
// Two combinational read ports with same-cycle write-to-read bypass,
// optional hardwired-zero entry 7, a sticky illegal-select flag and a
// wrapping count of committed writes.
module regbank8x64 #(
  parameter int WIDTH    = 64,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             sel_err,
  output logic [15:0]      wr_count
);

  logic [WIDTH-1:0] mem [8];

  logic       sel_none;
  logic       sel_onehot;
  logic       sel_illegal;
  logic       discard;
  logic       commit;
  logic [2:0] wr_idx;

  // A select is one-hot when it is nonzero and clearing its lowest set bit
  // leaves nothing behind. Anything else that is nonzero is multi-hot.
  // Writes seen while reset is held never commit, so they cannot bypass.
  assign sel_none    = (wr_sel == 8'h00);
  assign sel_onehot  = !sel_none && ((wr_sel & 8'(wr_sel - 8'd1)) == 8'h00);
  assign sel_illegal = !sel_none && !sel_onehot;
  assign discard     = ZERO_REG && wr_sel[7];
  assign commit      = sel_onehot && !discard && reset_n;

  // Encode the one-hot select into an entry index (only meaningful when one-hot).
  always_comb begin
    wr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (wr_sel[i]) begin
        wr_idx = 3'(i);
      end
    end
  end

  // Storage: committed writes land in the selected entry at the rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Sticky error flag: a multi-hot select wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else if (sel_illegal) begin
      sel_err <= 1'b1;
    end else if (clr_err) begin
      sel_err <= 1'b0;
    end
  end

  // Count committed writes only; discarded and illegal writes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count <= 16'h0000;
    end else if (commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // Read port A: zero register first, then bypass of this cycle's write.
  always_comb begin
    rd_data_a = mem[rd_addr_a];
    if (ZERO_REG && (rd_addr_a == 3'd7)) begin
      rd_data_a = '0;
    end else if (commit && (wr_idx == rd_addr_a)) begin
      rd_data_a = wr_data;
    end
  end

  // Read port B: identical to port A, fully independent address.
  always_comb begin
    rd_data_b = mem[rd_addr_b];
    if (ZERO_REG && (rd_addr_b == 3'd7)) begin
      rd_data_b = '0;
    end else if (commit && (wr_idx == rd_addr_b)) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: tb/tb_regbank8x64.sv
// tb_regbank8x64: directed self-checking bench for regbank8x64
// (default parameters: 64-bit entries, entry 7 hardwired to zero).
module tb_regbank8x64;

  logic        clk;
  logic        reset_n;
  logic [7:0]  wr_sel;
  logic [63:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        clr_err;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic        sel_err;
  logic [15:0] wr_count;

  int tests_run;
  int tests_failed;

  regbank8x64 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .clr_err   (clr_err),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .sel_err   (sel_err),
    .wr_count  (wr_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic [7:0] sel, input logic [63:0] data, input logic clr);
    wr_sel  = sel;
    wr_data = data;
    clr_err = clr;
  endtask

  // Advance past the next rising edge and settle one time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [63:0] exp_val;
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    rd_addr_a    = 3'd0;
    rd_addr_b    = 3'd0;
    applyStimulus(8'h00, 64'h0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_rd_a", rd_data_a, 64'h0);
    checkOutput("reset_err", {63'h0, sel_err}, 64'h0);
    checkOutput("reset_cnt", {48'h0, wr_count}, 64'h0);
    reset_n = 1'b1;
    #1;

    // Legal write to entry 2: bypass before the edge, storage after
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd3;
    applyStimulus(8'h04, 64'hDEAD_BEEF_0000_0001, 1'b0);
    #1;
    checkOutput("bypass_a", rd_data_a, 64'hDEAD_BEEF_0000_0001);
    checkOutput("no_bypass_b", rd_data_b, 64'h0);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    #1;
    checkOutput("stored_a", rd_data_a, 64'hDEAD_BEEF_0000_0001);
    checkOutput("cnt_after_first", {48'h0, wr_count}, 64'h1);

    // Write to the zero register is discarded
    rd_addr_a = 3'd7;
    rd_addr_b = 3'd7;
    applyStimulus(8'h80, {64{1'b1}}, 1'b0);
    #1;
    checkOutput("zero_bypass", rd_data_a, 64'h0);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    #1;
    checkOutput("zero_stored", rd_data_b, 64'h0);
    checkOutput("zero_cnt", {48'h0, wr_count}, 64'h1);
    checkOutput("zero_err", {63'h0, sel_err}, 64'h0);

    // Multi-hot select: no write, no bypass, flag sets
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd1;
    applyStimulus(8'h03, 64'h5, 1'b0);
    #1;
    checkOutput("illegal_nobyp_a", rd_data_a, 64'h0);
    checkOutput("illegal_nobyp_b", rd_data_b, 64'h0);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b1);
    #1;
    checkOutput("illegal_keep_a", rd_data_a, 64'h0);
    checkOutput("illegal_keep_b", rd_data_b, 64'h0);
    checkOutput("illegal_err", {63'h0, sel_err}, 64'h1);
    checkOutput("illegal_cnt", {48'h0, wr_count}, 64'h1);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    checkOutput("clr_err", {63'h0, sel_err}, 64'h0);

    // Clear coinciding with an illegal select keeps the flag
    applyStimulus(8'h03, 64'h5, 1'b0);
    tick();
    applyStimulus(8'h11, 64'h7, 1'b1);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    checkOutput("clr_vs_illegal", {63'h0, sel_err}, 64'h1);
    checkOutput("clr_vs_illegal_cnt", {48'h0, wr_count}, 64'h1);

    // Asynchronous reset mid-cycle while a legal write is presented
    rd_addr_a = 3'd2;
    rd_addr_b = 3'd0;
    applyStimulus(8'h01, 64'hAB, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_a", rd_data_a, 64'h0);
    checkOutput("rst_mid_b_nobyp", rd_data_b, 64'h0);
    checkOutput("rst_mid_err", {63'h0, sel_err}, 64'h0);
    checkOutput("rst_mid_cnt", {48'h0, wr_count}, 64'h0);
    tick();
    checkOutput("rst_held_b", rd_data_b, 64'h0);
    checkOutput("rst_held_cnt", {48'h0, wr_count}, 64'h0);
    #2;
    reset_n = 1'b1;
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    #1;
    checkOutput("rst_release_wr", rd_data_b, 64'hAB);
    checkOutput("rst_release_cnt", {48'h0, wr_count}, 64'h1);

    // Fresh reset, then fill entries 0..6 on consecutive edges
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(8'h01 << i, 64'h10 + 64'(i), 1'b0);
      tick();
    end
    applyStimulus(8'h00, 64'h0, 1'b0);
    checkOutput("fill_cnt", {48'h0, wr_count}, 64'h7);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      #1;
      exp_val = (a == 7) ? 64'h0 : 64'h10 + 64'(a);
      checkOutput($sformatf("sweep_a%0d", a), rd_data_a, exp_val);
      exp_val = (a == 0) ? 64'h0 : 64'h10 + 64'(7 - a);
      checkOutput($sformatf("sweep_b%0d", 7 - a), rd_data_b, exp_val);
    end

    // Back-to-back writes to the same entry: newest wins
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd3;
    applyStimulus(8'h08, 64'h1111, 1'b0);
    tick();
    applyStimulus(8'h08, 64'h2222, 1'b0);
    #1;
    checkOutput("b2b_bypass", rd_data_b, 64'h2222);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    #1;
    checkOutput("b2b_stored", rd_data_a, 64'h2222);
    checkOutput("b2b_cnt", {48'h0, wr_count}, 64'h9);

    // Counter wrap: 65537 legal writes after reset leave wr_count = 1
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      applyStimulus(8'h01 << (i % 7), 64'(i), 1'b0);
      tick();
    end
    checkOutput("cnt_max", {48'h0, wr_count}, 64'hFFFF);
    applyStimulus(8'h02, 64'h0, 1'b0);
    tick();
    checkOutput("cnt_wrap", {48'h0, wr_count}, 64'h0);
    tick();
    applyStimulus(8'h00, 64'h0, 1'b0);
    checkOutput("cnt_wrap_plus1", {48'h0, wr_count}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
